// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU request channel and a single-port RAM.
// Sub-word stores do a read-merge-write; illegal accesses return an error.
module mem_access_unit #(
  parameter int AW_WORDS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    RESP
  } state_t;

  state_t                state;
  logic [3:0]            op_q;
  logic [AW_WORDS+1:0]   addr_q;
  logic [31:0]           wd_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  op_ok;
  logic                  misalign;
  logic                  oor;
  logic                  req_err;

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [3:0]  op,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LBU:  r = {24'd0, b};
      OP_LHU:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [31:0] d,
    input logic [3:0]  op,
    input logic [1:0]  off
  );
    logic [31:0] r;
    r = w;
    if (op == OP_SB) begin
      r[{off, 3'b000} +: 8] = d[7:0];
    end else if (off[1]) begin
      r[31:16] = d[15:0];
    end else begin
      r[15:0] = d[15:0];
    end
    return r;
  endfunction

  always_comb begin
    op_ok    = 1'b0;
    misalign = 1'b0;
    case (req_op)
      OP_LB, OP_LBU, OP_SB: op_ok = 1'b1;
      OP_LH, OP_LHU, OP_SH: begin
        op_ok    = 1'b1;
        misalign = req_addr[0];
      end
      OP_LW, OP_SW: begin
        op_ok    = 1'b1;
        misalign = |req_addr[1:0];
      end
      default: op_ok = 1'b0;
    endcase
  end

  assign oor     = (req_addr >> (AW_WORDS + 2)) != 32'd0;
  assign req_err = !op_ok || misalign || oor;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_wd     = wd_q;
  assign mem_we     = (state == WRITE) && !reset;

  // Errors skip the RAM states entirely, so mem_a stays 0 for them.
  always_comb begin
    mem_a = 32'd0;
    if (state == READ || state == MERGE || state == WRITE) begin
      mem_a = {{(32 - AW_WORDS){1'b0}}, addr_q[AW_WORDS+1:2]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr[AW_WORDS+1:0];
            wd_q    <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
            if (req_err) begin
              state <= RESP;
            end else if (req_op == OP_SW) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          state <= MERGE;
        end
        MERGE: begin
          if (op_q[3]) begin
            wd_q  <= merge(mem_rd, wd_q, op_q, addr_q[1:0]);
            state <= WRITE;
          end else begin
            rdata_q <= load_ext(mem_rd, op_q, addr_q[1:0]);
            state   <= RESP;
          end
        end
        WRITE: begin
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
